// File: rtl/mux4x1_rr_sched.sv
// Round-robin scheduler for a shared 4:1 mux: one-hot grant, hold limit of MAX_HOLD
// cycles per ownership, zero-bubble handoff, bit-swapped select encoding.
module mux4x1_rr_sched #(
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_id,
   output logic [1:0] sel,
   output logic       busy
);

   localparam int unsigned CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

   typedef enum logic [0:0] {IDLE, GRANT} state_t;

   state_t           state_q, state_d;
   logic [3:0]       gnt_q, gnt_d;
   logic [1:0]       gnt_id_q, gnt_id_d;
   logic [1:0]       sel_q, sel_d;
   logic             busy_q, busy_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       win;
   logic [1:0]       start;

   // Returns {found, index} of the first set bit searching start, start+1, ... mod 4.
   function automatic logic [2:0] pick_rr(input logic [3:0] r, input logic [1:0] s);
      logic [2:0] res;
      logic [1:0] idx;
      res = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         idx = s + 2'(i);
         if (!res[2] && r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      gnt_id_d = gnt_id_q;
      sel_d    = sel_q;
      busy_d   = busy_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      start    = ptr_q;
      win      = '0;

      case (state_q)
         IDLE: begin
            gnt_d  = '0;
            busy_d = 1'b0;
            win    = pick_rr(req, ptr_q);
         end
         GRANT: begin
            if (!req[gnt_id_q] || cnt_q == CNT_MAX) begin
               // Searching from owner+1 leaves the owner last, so it only wins when alone.
               start  = gnt_id_q + 2'd1;
               ptr_d  = start;
               win    = pick_rr(req, start);
               if (!win[2]) begin
                  state_d = IDLE;
                  gnt_d   = '0;
                  busy_d  = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (win[2]) begin
         state_d  = GRANT;
         gnt_d    = 4'b0001 << win[1:0];
         gnt_id_d = win[1:0];
         sel_d    = {win[0], win[1]};
         busy_d   = 1'b1;
         cnt_d    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         gnt_id_q <= '0;
         sel_q    <= '0;
         busy_q   <= 1'b0;
         ptr_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
         sel_q    <= sel_d;
         busy_q   <= busy_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign gnt    = gnt_q;
   assign gnt_id = gnt_id_q;
   assign sel    = sel_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_mux4x1_rr_sched.sv
// Scoreboard bench for mux4x1_rr_sched: a cycle model queues expected outputs per edge,
// directed tests add fixed expectations taken from the behaviour description.
module tb_mux4x1_rr_sched;

   localparam int MH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = '0;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic [1:0] sel;
   logic       busy;

   int errs = 0;
   int checks = 0;

   typedef struct packed {
      logic [3:0] gnt;
      logic [1:0] id;
      logic [1:0] sel;
      logic       busy;
   } exp_t;

   exp_t exp_q[$];

   // reference model state
   int         m_owner = 0;
   int         m_cnt = 0;
   int         m_ptr = 0;
   logic       m_busy = 1'b0;
   logic [3:0] m_gnt = '0;
   logic [1:0] m_id = '0;
   logic [1:0] m_sel = '0;

   mux4x1_rr_sched #(.MAX_HOLD(MH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .gnt   (gnt),
      .gnt_id(gnt_id),
      .sel   (sel),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %b expected %b at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int m_pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++) begin
         int c;
         c = (p + k) % 4;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   function automatic logic [1:0] sel_of(input int o);
      case (o)
         0: return 2'b00;
         1: return 2'b10;
         2: return 2'b01;
         default: return 2'b11;
      endcase
   endfunction

   task automatic m_grant(input int w);
      m_owner = w;
      m_cnt   = 0;
      m_busy  = 1'b1;
      m_gnt   = 4'b0001 << w;
      m_id    = 2'(w);
      m_sel   = sel_of(w);
   endtask

   task automatic m_step(input logic [3:0] r, input logic rn);
      int w;
      if (!rn) begin
         m_owner = 0; m_cnt = 0; m_ptr = 0; m_busy = 1'b0;
         m_gnt = '0; m_id = '0; m_sel = '0;
      end else if (!m_busy) begin
         w = m_pick(r, m_ptr);
         if (w >= 0) m_grant(w);
      end else if (!r[m_owner] || m_cnt == MH - 1) begin
         m_ptr = (m_owner + 1) % 4;
         w = m_pick(r, m_ptr);
         if (w >= 0) m_grant(w);
         else begin
            m_busy = 1'b0;
            m_gnt  = '0;
         end
      end else begin
         m_cnt++;
      end
   endtask

   // Drive one cycle of stimulus, queue the model's expectation, compare after the edge.
   task automatic tick(input logic [3:0] r, input logic rn);
      exp_t e;
      @(negedge clk);
      req   = r;
      rst_n = rn;
      m_step(r, rn);
      exp_q.push_back('{gnt: m_gnt, id: m_id, sel: m_sel, busy: m_busy});
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk("queue_empty", 4'd1, 4'd0);
      end else begin
         e = exp_q.pop_front();
         chk("gnt", gnt, e.gnt);
         chk("gnt_id", {2'b00, gnt_id}, {2'b00, e.id});
         chk("sel", {2'b00, sel}, {2'b00, e.sel});
         chk("busy", {3'b000, busy}, {3'b000, e.busy});
         chk("onehot", ($countones(gnt) <= 1) ? 4'd1 : 4'd0, 4'd1);
      end
   endtask

   initial begin
      // reset then idle
      tick(4'b0000, 1'b0);
      tick(4'b0000, 1'b0);
      chk("rst_gnt", gnt, 4'b0000);
      chk("rst_busy", {3'b000, busy}, 4'd0);
      tick(4'b0000, 1'b1);
      tick(4'b0000, 1'b1);

      // single request on source 2
      tick(4'b0100, 1'b1);
      chk("single_gnt", gnt, 4'b0100);
      chk("single_sel", {2'b00, sel}, 4'b0001);
      chk("single_id", {2'b00, gnt_id}, 4'd2);
      tick(4'b0100, 1'b1);
      tick(4'b0100, 1'b1);
      chk("single_hold", gnt, 4'b0100);
      tick(4'b0000, 1'b1);
      chk("single_rel", gnt, 4'b0000);
      chk("single_idle", {3'b000, busy}, 4'd0);

      // hold limit and rotation from ptr=0
      tick(4'b0000, 1'b0);
      for (int k = 0; k < 17; k++) begin
         tick(4'b1111, 1'b1);
         chk("rot_order", {2'b00, gnt_id}, 4'((k / 4) % 4));
      end

      // lone persistent requester
      for (int k = 0; k < 10; k++) begin
         tick(4'b0010, 1'b1);
         chk("lone", gnt, 4'b0010);
      end

      // fairness: owner 3 drops while source 0 waits
      tick(4'b0000, 1'b0);
      tick(4'b1000, 1'b1);
      chk("fair_own3", gnt, 4'b1000);
      tick(4'b1001, 1'b1);
      tick(4'b0001, 1'b1);
      chk("fair_gnt0", gnt, 4'b0001);
      chk("fair_sel0", {2'b00, sel}, 4'b0000);

      // reset mid-grant
      tick(4'b0000, 1'b0);
      tick(4'b0010, 1'b1);
      tick(4'b1010, 1'b1);
      tick(4'b1010, 1'b0);
      chk("midrst_gnt", gnt, 4'b0000);
      tick(4'b1010, 1'b1);
      chk("midrst_regnt", gnt, 4'b0010);

      // random traffic with occasional reset
      for (int k = 0; k < 300; k++) begin
         tick(4'($urandom_range(0, 15)), ($urandom_range(0, 49) != 0));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/mux4x1_rr_sched.md
Name: mux4x1_rr_sched

Overview:
- Round-robin scheduler that shares the 4:1 mux datapath among four requesters.
- Each requester raises req[i]; the scheduler grants one at a time and drives the mux select.
- A granted requester holds the mux for at most MAX_HOLD consecutive cycles, then ownership rotates.
- Sits beside the 4:1 mux; its sel output connects directly to the mux select pins.

Parameters:
- MAX_HOLD, 4, max consecutive grant cycles per ownership; legal range 1..16; counter width derived internally.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- req  input  4  request per source; bit i = mux data input a[i]
- gnt  output  4  registered one-hot grant; all-zero when idle
- gnt_id  output  2  binary index of current/last owner
- sel  output  2  mux select, bit-swapped encoding: sel = {gnt_id[0], gnt_id[1]}
- busy  output  1  high while any gnt bit is high

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low; sampled only on a rising clk edge.
- Reset values: gnt=0, gnt_id=0, sel=2'b00, busy=0, rotation pointer ptr=0, hold counter cnt=0, state IDLE.
- Select mapping (mux wiring: sel[1] picks within a pair, sel[0] picks the pair):
  - owner 0 -> 2'b00, owner 1 -> 2'b10, owner 2 -> 2'b01, owner 3 -> 2'b11.
- All outputs are registered; there is no combinational path from req to any output.
- State IDLE:
  - If req != 0, pick the first set bit searching ptr, ptr+1, ... (mod 4).
  - Next edge: gnt = onehot(winner), gnt_id = winner, busy=1, cnt=0, go to GRANT.
  - If req == 0: remain in IDLE; gnt=0; gnt_id and sel hold their last values.
- State GRANT, owner o:
  - Release when req[o]==0 or cnt==MAX_HOLD-1.
  - Otherwise cnt increments and the grant holds.
- On release:
  - ptr = o+1 (mod 4).
  - Re-arbitrate in the same cycle over current req using the new ptr.
  - Owner o is eligible only if no other bit is set and req[o] is still high.
  - If a winner exists: next edge grants it with cnt=0 (zero-bubble handoff).
  - If no winner: next edge gnt=0, busy=0, go to IDLE.
- Latency: request-to-grant is 1 cycle from IDLE. Release-to-new-grant is 1 cycle, with no idle gap.
- Maximum wait for a continuously requesting source: 3*MAX_HOLD + 1 cycles.
- MAX_HOLD=1: every grant lasts exactly one cycle; continuous requesters rotate every cycle.
- Simultaneous requests: resolved strictly by rotation order from ptr; no fixed priority.
- Owner drops req in the same cycle another source raises req: treated as a normal release; the new source is eligible immediately.
- gnt is always one-hot or zero; two bits are never high together.
- Reset mid-grant (rst_n low at an edge): all state returns to reset values on that edge, including ptr=0.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, req=0 -> gnt=0, sel=00, busy=0, gnt_id=0 every cycle.
- Single request: req=4'b0100 from IDLE at cycle N; drop at N+3.
  - Required: gnt=0100, sel=01, gnt_id=2 at N+1.
  - Grant held through N+3; gnt=0 and busy=0 at N+4.
- Hold limit and rotation: MAX_HOLD=4, req=4'b1111 held constant.
  - Required grant order 0,1,2,3,0, each lasting exactly 4 cycles.
  - Handoffs are back-to-back; sel sequence 00,10,01,11.
- Lone persistent requester: req=4'b0010 held for 10 cycles, MAX_HOLD=4.
  - Required: gnt=0010 for all 10 cycles after the first; release and re-grant to itself with no gap; cnt restarts.
- Fairness after release: owner 3 drops req while req=4'b1001.
  - Required: ptr wraps to 0; source 0 granted next cycle, sel=00.
- Reset mid-grant: owner 1 in its 2nd hold cycle, rst_n=0 for one edge, req kept at 4'b1010.
  - Required: gnt=0 after that edge.
  - After rst_n returns high: source 1 granted first (ptr=0, first set bit at or after 0).
